cfu_issuer: RTL and testbench

Initiator side of the CFU custom-instruction interface. Accepts operation requests (funct3, funct7, two 32-bit operands) through a valid/ready command port and buffers them in a small FIFO. Issues each request to a `cfu` instance with a one-cycle enable and holds the operands while the CFU stalls. Returns each result, or a timeout error, on a valid/ready response port. It lets a DMA engine or MMIO block stream operations into the CFU without the CPU pipeline.

---
 rtl/cfu_issuer.sv | 145 ++++++++++++++
 tb/tb_cfu_issuer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_issuer.sv
// Command-FIFO driven initiator for a CFU: pops one request at a time, strobes
// the CFU, waits out stalls (with timeout) and presents the result on a response port.
module cfu_issuer #(
   parameter int CMD_DEPTH = 4,
   parameter int TIMEOUT   = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           cmd_valid_i,
   output logic                           cmd_ready_o,
   input  logic [2:0]                     cmd_funct3_i,
   input  logic [6:0]                     cmd_funct7_i,
   input  logic [31:0]                    cmd_src1_i,
   input  logic [31:0]                    cmd_src2_i,
   output logic                           rsp_valid_o,
   input  logic                           rsp_ready_i,
   output logic [31:0]                    rsp_data_o,
   output logic                           rsp_err_o,
   output logic                           cfu_en_o,
   output logic [2:0]                     cfu_funct3_o,
   output logic [6:0]                     cfu_funct7_o,
   output logic [31:0]                    cfu_src1_o,
   output logic [31:0]                    cfu_src2_o,
   input  logic                           cfu_stall_i,
   input  logic [31:0]                    cfu_rslt_i,
   output logic                           busy_o,
   output logic [$clog2(CMD_DEPTH):0]     cmd_count_o
);

   localparam int AW = $clog2(CMD_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 3 + 7 + 32 + 32;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          state_reg, state_next;
   logic [EW-1:0]   fifo_mem [CMD_DEPTH];
   logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [EW-1:0]   op_reg;
   logic [15:0]     tmo_cnt_reg, tmo_cnt_next;
   logic [31:0]     rsp_data_reg, rsp_data_next;
   logic            rsp_err_reg, rsp_err_next;
   logic            push, pop;

   // A pop in IDLE frees a slot this cycle, so a full FIFO may still take a push.
   assign pop         = (state_reg == S_IDLE) && (count_reg != '0);
   assign cmd_ready_o = (count_reg != CW'(CMD_DEPTH)) || pop;
   assign push        = cmd_valid_i && cmd_ready_o;

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= {cmd_funct3_i, cmd_funct7_i, cmd_src1_i, cmd_src2_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         op_reg     <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            op_reg     <= fifo_mem[rd_ptr_reg];
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg    <= S_IDLE;
         tmo_cnt_reg  <= '0;
         rsp_data_reg <= '0;
         rsp_err_reg  <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tmo_cnt_reg  <= tmo_cnt_next;
         rsp_data_reg <= rsp_data_next;
         rsp_err_reg  <= rsp_err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      tmo_cnt_next  = tmo_cnt_reg;
      rsp_data_next = rsp_data_reg;
      rsp_err_next  = rsp_err_reg;
      cfu_en_o      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (pop) begin
               tmo_cnt_next = '0;
               state_next   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cfu_en_o = 1'b1;
            if (!cfu_stall_i) begin
               rsp_data_next = cfu_rslt_i;
               rsp_err_next  = 1'b0;
               state_next    = S_RESP;
            end else begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            // tmo_cnt_reg counts stalled WAIT cycles already spent.
            if (!cfu_stall_i) begin
               rsp_data_next = cfu_rslt_i;
               rsp_err_next  = 1'b0;
               state_next    = S_RESP;
            end else if (tmo_cnt_reg == 16'(TIMEOUT - 1)) begin
               rsp_data_next = '0;
               rsp_err_next  = 1'b1;
               state_next    = S_RESP;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready_i) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign rsp_valid_o  = (state_reg == S_RESP);
   assign rsp_data_o   = rsp_data_reg;
   assign rsp_err_o    = rsp_err_reg;
   assign cfu_funct3_o = op_reg[73:71];
   assign cfu_funct7_o = op_reg[70:64];
   assign cfu_src1_o   = op_reg[63:32];
   assign cfu_src2_o   = op_reg[31:0];
   assign busy_o       = (state_reg != S_IDLE) || (count_reg != '0);
   assign cmd_count_o  = count_reg;

endmodule

// File: tb/tb_cfu_issuer.sv
// Scoreboard bench for cfu_issuer: the bench plays the CFU, predicts each response
// when its command is pushed, and a negedge monitor checks everything the DUT presents.
module tb_cfu_issuer;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [2:0]  cmd_funct3_i = '0;
   logic [6:0]  cmd_funct7_i = '0;
   logic [31:0] cmd_src1_i = '0;
   logic [31:0] cmd_src2_i = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_data_o;
   logic        rsp_err_o;
   logic        cfu_en_o;
   logic [2:0]  cfu_funct3_o;
   logic [6:0]  cfu_funct7_o;
   logic [31:0] cfu_src1_o;
   logic [31:0] cfu_src2_o;
   logic        cfu_stall_i = 1'b0;
   logic [31:0] cfu_rslt_i = '0;
   logic        busy_o;
   logic [2:0]  cmd_count_o;

   cfu_issuer #(.CMD_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_funct3_i(cmd_funct3_i), .cmd_funct7_i(cmd_funct7_i),
      .cmd_src1_i(cmd_src1_i), .cmd_src2_i(cmd_src2_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
      .cfu_en_o(cfu_en_o), .cfu_funct3_o(cfu_funct3_o), .cfu_funct7_o(cfu_funct7_o),
      .cfu_src1_o(cfu_src1_o), .cfu_src2_o(cfu_src2_o),
      .cfu_stall_i(cfu_stall_i), .cfu_rslt_i(cfu_rslt_i),
      .busy_o(busy_o), .cmd_count_o(cmd_count_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [2:0] f3; logic [6:0] f7; logic [31:0] s1; logic [31:0] s2; } cmd_t;
   typedef struct { logic err; logic [31:0] data; int lat; } exp_t;

   cmd_t cmd_q[$];
   exp_t exp_q[$];
   int   stall_q[$];

   int vectors = 0, miscompares = 0;
   int cyc = 0;
   int pushed_cnt = 0, en_cnt = 0, done_cnt = 0, full_push_cnt = 0;
   int last_hs_cyc = 0, last_en_cyc = 0, last_rsp_cyc = 0;
   int rr_mode = 0;
   bit f5_done = 1'b0;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference CFU operation set used by the bench's CFU.
   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [31:0] a, input logic [31:0] b);
      case (f3)
         3'd0:    return a | b;
         3'd1:    return a + b;
         3'd2:    return a ^ b;
         default: return (a - b) ^ {25'd0, f7};
      endcase
   endfunction

   task automatic send(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] s1, input logic [31:0] s2, input int n);
      bit fire = 1'b0;
      bit full_now;
      int hs;
      exp_t e;
      cmd_funct3_i = f3; cmd_funct7_i = f7; cmd_src1_i = s1; cmd_src2_i = s2;
      cmd_valid_i  = 1'b1;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk_i);
         fire     = cmd_ready_o;
         full_now = (cmd_count_o == 3'(DEPTH));
         hs       = cyc;
         @(posedge clk_i);
         if (fire) break;
      end
      chk("cmd_accepted", fire, 1);
      if (fire) begin
         cmd_q.push_back('{f3, f7, s1, s2});
         stall_q.push_back(n);
         e.err  = (n > TMO);
         e.data = e.err ? 32'd0 : ref_op(f3, f7, s1, s2);
         e.lat  = ((n > TMO) ? TMO : n) + 1;
         exp_q.push_back(e);
         pushed_cnt++;
         last_hs_cyc = hs;
         if (full_now) full_push_cnt++;
      end
      #1 cmd_valid_i = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 3000 && done_cnt != pushed_cnt; t++) @(posedge clk_i);
      chk("drain_all_responses", done_cnt, pushed_cnt);
      @(posedge clk_i); #1;
   endtask

   task automatic wait_rsp();
      bit seen = 1'b0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk_i);
         if (rsp_valid_o) begin seen = 1'b1; break; end
      end
      chk("rsp_appears", seen, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
      chk({tag, "_rsp_data"}, rsp_data_o, 0);
      chk({tag, "_rsp_err"}, rsp_err_o, 0);
      chk({tag, "_cfu_en"}, cfu_en_o, 0);
      chk({tag, "_cfu_ops"}, {cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o}, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_count"}, cmd_count_o, 0);
      chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
   endtask

   // Response-consumer handshake driver.
   initial forever begin
      @(posedge clk_i); #2;
      case (rr_mode)
         0:       rsp_ready_i = 1'b1;
         1:       rsp_ready_i = 1'($urandom_range(0, 1));
         default: rsp_ready_i = 1'b0;
      endcase
   end

   // Bench CFU: stalls N cycles from the enable, garbage result until done.
   initial begin
      int n_cur = 0, k = 0;
      bit act = 1'b0;
      forever begin
         @(posedge clk_i); #1;
         if (rst_i) begin
            act = 1'b0; cfu_stall_i = 1'b0; cfu_rslt_i = $urandom;
         end else begin
            if (cfu_en_o) begin
               n_cur = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
               k = 0; act = 1'b1;
            end else if (act) begin
               k++;
            end
            if (act && k < n_cur) begin
               cfu_stall_i = 1'b1; cfu_rslt_i = $urandom;
            end else if (act && k == n_cur) begin
               cfu_stall_i = 1'b0;
               cfu_rslt_i  = ref_op(cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o);
               act = 1'b0;
            end else begin
               cfu_stall_i = 1'b0; cfu_rslt_i = $urandom;
            end
         end
      end
   end

   // Monitor / scoreboard.
   initial begin
      bit   prev_en = 1'b0, prev_valid = 1'b0, op_active = 1'b0;
      int   en_cyc = 0, qd;
      logic [73:0] snap = '0;
      cmd_t c;
      exp_t cur = '{1'b0, 32'd0, 0};
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            prev_en = 1'b0; prev_valid = 1'b0; op_active = 1'b0;
            en_cnt = 0; done_cnt = 0;
         end else begin
            if (cfu_en_o) begin
               chk("en_not_consecutive", prev_en, 0);
               chk("en_single_outstanding", op_active, 0);
               if (cmd_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL unexpected_issue: cfu_en_o with no command pending (cycle %0d)", cyc);
               end else begin
                  c = cmd_q.pop_front();
                  chk("issue_operands", {cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o},
                      {c.f3, c.f7, c.s1, c.s2});
               end
               snap = {cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o};
               op_active = 1'b1; en_cyc = cyc; last_en_cyc = cyc; en_cnt++;
            end else if (op_active) begin
               chk("operands_stable", {cfu_funct3_o, cfu_funct7_o, cfu_src1_o, cfu_src2_o}, snap);
            end
            if (rsp_valid_o && !prev_valid) begin
               if (exp_q.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL unexpected_response: data 0x%0h err %0d (cycle %0d)", rsp_data_o, rsp_err_o, cyc);
               end else begin
                  cur = exp_q.pop_front();
                  chk("rsp_data", rsp_data_o, cur.data);
                  chk("rsp_err", rsp_err_o, cur.err);
                  chk("rsp_latency_from_en", cyc - en_cyc, cur.lat);
               end
               last_rsp_cyc = cyc;
            end else if (rsp_valid_o) begin
               chk("rsp_data_stable", rsp_data_o, cur.data);
               chk("rsp_err_stable", rsp_err_o, cur.err);
            end
            qd = pushed_cnt - en_cnt;
            chk("cmd_count", cmd_count_o, qd);
            chk("busy", busy_o, (qd != 0) || op_active);
            if (qd < DEPTH) chk("cmd_ready_not_full", cmd_ready_o, 1);
            else if (rsp_valid_o) chk("cmd_ready_full", cmd_ready_o, 0);
            if (rsp_valid_o && rsp_ready_i) begin
               op_active = 1'b0; done_cnt++;
            end
            prev_en = cfu_en_o; prev_valid = rsp_valid_o;
         end
      end
   end

   initial begin
      int d0;
      int picks[10] = '{0, 0, 1, 2, 3, 5, 7, 8, 9, 12};
      #1 rst_i = 1'b1;
      #1 check_reset_outputs("reset");
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // Zero-stall OR: en 2 cycles after handshake, response at 3.
      send(3'd0, 7'd0, 32'h0000_00F0, 32'h0000_000F, 0);
      drain();
      chk("issue_cycle_after_hs", last_en_cyc - last_hs_cyc, 2);
      chk("rsp_cycle_after_hs", last_rsp_cyc - last_hs_cyc, 3);

      // Five stall cycles: response at cycle 8.
      send(3'd1, 7'd3, 32'hA5A5_0000, 32'h0000_5A5A, 5);
      drain();
      chk("rsp_cycle_stall5", last_rsp_cyc - last_hs_cyc, 8);

      // Timeout then a normal command; boundaries at TIMEOUT and TIMEOUT+1.
      send(3'd2, 7'h11, 32'h1234_5678, 32'h0F0F_0F0F, 40);
      send(3'd1, 7'd0, 32'd100, 32'd23, 0);
      send(3'd5, 7'h2A, 32'hDEAD_BEEF, 32'h0000_1111, TMO);
      send(3'd3, 7'h01, 32'h8000_0000, 32'h0000_0001, TMO + 1);
      drain();

      // Fill the FIFO behind a held response.
      rr_mode = 2;
      send(3'd0, 7'd0, 32'h1, 32'h2, 0);
      send(3'd1, 7'd0, 32'h10, 32'h20, 0);
      send(3'd2, 7'd0, 32'h30, 32'h40, 1);
      send(3'd0, 7'd0, 32'h50, 32'h60, 0);
      send(3'd4, 7'h7F, 32'h70, 32'h80, 2);
      @(negedge clk_i);
      chk("fill_count", cmd_count_o, DEPTH);
      chk("fill_ready_low", cmd_ready_o, 0);
      @(posedge clk_i); #1;
      fork
         begin send(3'd1, 7'd9, 32'h0BAD_F00D, 32'h1, 0); f5_done = 1'b1; end
      join_none
      repeat (3) @(posedge clk_i);
      #1 rr_mode = 0;
      @(posedge clk_i); #1 rr_mode = 2;
      for (int t = 0; t < 50 && !f5_done; t++) @(posedge clk_i);
      chk("push_while_full_done", f5_done, 1);
      chk("push_while_full_seen", full_push_cnt > 0, 1);
      for (int i = 0; i < 5; i++) begin
         wait_rsp();
         d0 = done_cnt;
         @(posedge clk_i); #1 rr_mode = 0;
         @(posedge clk_i); #1 rr_mode = 2;
         repeat (4) @(posedge clk_i);
         chk("one_rsp_per_pulse", done_cnt - d0, 1);
      end
      rr_mode = 0;
      drain();

      // Backpressure: response held >10 cycles while more commands arrive.
      rr_mode = 2;
      send(3'd2, 7'd5, 32'hCAFE_0000, 32'h0000_BABE, 1);
      wait_rsp();
      @(posedge clk_i); #1;
      send(3'd1, 7'd0, 32'd7, 32'd8, 0);
      send(3'd0, 7'd0, 32'd9, 32'd6, 0);
      repeat (8) @(posedge clk_i);
      @(negedge clk_i);
      chk("bp_queued", cmd_count_o, 2);
      chk("bp_rsp_held", rsp_valid_o, 1);
      @(posedge clk_i); #1 rr_mode = 0;
      drain();

      // Asynchronous reset mid-WAIT with three commands queued.
      send(3'd1, 7'd0, 32'h11, 32'h22, 6);
      send(3'd0, 7'd0, 32'h33, 32'h44, 0);
      send(3'd0, 7'd0, 32'h55, 32'h66, 0);
      send(3'd0, 7'd0, 32'h77, 32'h88, 0);
      chk("pre_reset_queued", cmd_count_o, 3);
      chk("pre_reset_waiting", {cfu_stall_i, rsp_valid_o, cfu_en_o}, 3'b100);
      #2 rst_i = 1'b1;
      cmd_q.delete(); exp_q.delete(); stall_q.delete(); pushed_cnt = 0;
      #1 check_reset_outputs("async_reset");
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      repeat (20) @(posedge clk_i);
      @(negedge clk_i);
      chk("no_rsp_after_reset", done_cnt, 0);
      chk("idle_after_reset", {busy_o, rsp_valid_o, cmd_count_o}, 0);
      @(posedge clk_i); #1;

      // Randomized traffic with random consumer backpressure.
      rr_mode = 1;
      for (int i = 0; i < 60; i++) begin
         repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
         send(3'($urandom_range(0, 7)), 7'($urandom_range(0, 127)), $urandom, $urandom,
              picks[$urandom_range(0, 9)]);
      end
      rr_mode = 0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
